uart_tx_unit: RTL

UART transmitter that drains the FIFO buffer. Sits directly downstream of `fifo_unit`: it watches `empty`, pops one word with a single-cycle `rd` pulse, and serializes that word on `tx` as an 8N1-style frame: start bit, DATA_WIDTH data bits LSB first, one stop bit. Its integrated bit-period counter removes the need for a separate baud generator.

---
 rtl/uart_tx_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter that drains a first-word-fall-through FIFO: one pop per frame,
// then a start bit, DATA_WIDTH data bits LSB first and one stop bit on tx.
module uart_tx_unit #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !reset) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (idx_q == IDX_LAST)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx, busy and the done tick are computed one cycle ahead so all three leave flops.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        fifo_rd = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                fifo_rd = !fifo_empty && !reset;
                if (fifo_rd) begin
                    shift_d = fifo_r_data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    idx_d = '0;
                    tx_d  = shift_q[0];
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        tx_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_d[0];
                    end
                end
            end
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                tx_d  = 1'b1;
            end
            default: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign tx_done_tick = done_q;

endmodule
